// File: rtl/processor_step_ctrl_pkg.sv
// rtl/processor_step_ctrl_pkg.sv - shared types and widths for the run/step/breakpoint sequencer
package step_ctrl_pkg;

  typedef enum logic [1:0] {
    M_IDLE = 2'd0,
    M_STEP = 2'd1,
    M_RUN  = 2'd2,
    M_BRK  = 2'd3
  } mode_t;

  localparam int EN_CNT_W = 16;

endpackage

// File: rtl/processor_step_ctrl_if.sv
// rtl/processor_step_ctrl_if.sv - KEY/SW requests in, processor enable and display status out
interface processor_step_ctrl_if
  import step_ctrl_pkg::*;
#(
  parameter int PC_W = 7,
  parameter int ST_W = 4
);

  logic                StepReq;
  logic                RunToggle;
  logic                BreakEn;
  logic [PC_W-1:0]     BreakPC;
  logic [PC_W-1:0]     PC;
  logic [ST_W-1:0]     ProcState;
  logic                ProcEn;
  logic [1:0]          Mode;
  logic                Halted;
  logic [EN_CNT_W-1:0] EnCount;

  modport master (
    output StepReq, RunToggle, BreakEn, BreakPC, PC, ProcState,
    input  ProcEn, Mode, Halted, EnCount
  );

  modport slave (
    input  StepReq, RunToggle, BreakEn, BreakPC, PC, ProcState,
    output ProcEn, Mode, Halted, EnCount
  );

endinterface

// File: rtl/processor_step_ctrl_run_rate_divider.sv
// rtl/processor_step_ctrl_run_rate_divider.sv - free-running RUN-rate divider, one Tick per RUN_DIV cycles
module run_rate_divider #(
  parameter int RUN_DIV = 25_000_000,
  parameter int DIV_W   = 25
) (
  input  logic Clock,
  input  logic ResetN,
  input  logic Clear,
  input  logic Enable,
  output logic Tick
);

  localparam logic [DIV_W-1:0] TERM = DIV_W'(RUN_DIV - 1);

  logic [DIV_W-1:0] count;

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      count <= '0;
    end else if (Clear) begin
      count <= '0;
    end else if (Enable) begin
      count <= (count == TERM) ? '0 : count + DIV_W'(1);
    end
  end

  assign Tick = Enable && !Clear && (count == TERM);

endmodule

// File: rtl/processor_step_ctrl.sv
// rtl/processor_step_ctrl.sv - run/step/breakpoint sequencer issuing one-cycle processor enables
module processor_step_ctrl
  import step_ctrl_pkg::*;
#(
  parameter int              RUN_DIV     = 25_000_000,
  parameter int              DIV_W       = 25,
  parameter int              PC_W        = 7,
  parameter int              ST_W        = 4,
  parameter logic [ST_W-1:0] FETCH_STATE = '0
) (
  input  logic                  Clock,
  input  logic                  ResetN,
  processor_step_ctrl_if.slave  ctl
);

  mode_t               state;
  mode_t               state_next;
  logic                proc_en;
  logic                en_next;
  logic                resume;
  logic                resume_next;
  logic                at_break;
  logic                tick;
  logic                in_run;
  logic [EN_CNT_W-1:0] en_count;

  assign in_run = (state == M_RUN);

  // Divider only runs in RUN, so every entry into RUN starts a full period.
  run_rate_divider #(
    .RUN_DIV (RUN_DIV),
    .DIV_W   (DIV_W)
  ) u_div (
    .Clock  (Clock),
    .ResetN (ResetN),
    .Clear  (!in_run),
    .Enable (in_run),
    .Tick   (tick)
  );

  assign at_break = ctl.BreakEn && (ctl.PC == ctl.BreakPC) &&
                    (ctl.ProcState == FETCH_STATE) && !resume;

  always_comb begin
    state_next  = state;
    en_next     = 1'b0;
    resume_next = resume;
    unique case (state)
      M_IDLE: begin
        if (ctl.RunToggle) begin
          state_next = M_RUN;
        end else if (ctl.StepReq) begin
          state_next = M_STEP;
          en_next    = 1'b1;
        end
      end
      M_STEP: begin
        state_next = M_IDLE;
      end
      M_RUN: begin
        if (ctl.RunToggle) begin
          state_next = M_IDLE;
        end else if (tick) begin
          if (at_break) begin
            state_next = M_BRK;
          end else begin
            en_next     = 1'b1;
            resume_next = 1'b0;
          end
        end
      end
      M_BRK: begin
        // Leaving a breakpoint arms resume so the same PC is not trapped again.
        if (ctl.RunToggle) begin
          state_next  = M_RUN;
          resume_next = 1'b1;
        end else if (ctl.StepReq) begin
          state_next  = M_STEP;
          en_next     = 1'b1;
          resume_next = 1'b1;
        end
      end
      default: begin
        state_next = M_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state    <= M_IDLE;
      proc_en  <= 1'b0;
      resume   <= 1'b0;
      en_count <= '0;
    end else begin
      state   <= state_next;
      proc_en <= en_next;
      resume  <= resume_next;
      if (en_next) begin
        en_count <= en_count + EN_CNT_W'(1);
      end
    end
  end

  assign ctl.ProcEn  = proc_en;
  assign ctl.Mode    = state;
  assign ctl.Halted  = (state == M_IDLE) || (state == M_BRK);
  assign ctl.EnCount = en_count;

endmodule

// File: tb/tb_processor_step_ctrl.sv
// tb/tb_processor_step_ctrl.sv - directed bench with enable scoreboard for processor_step_ctrl
module tb_processor_step_ctrl;
  import step_ctrl_pkg::*;

  typedef struct {
    int          at;
    logic [15:0] cnt;
  } exp_t;

  logic        Clock = 1'b0;
  logic        ResetN;
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;
  logic [15:0] exp_cnt = '0;
  exp_t        sb[$];
  exp_t        got;
  int          model_en = 0;
  int          en_base = 0;
  int          pc_base = 0;
  int          adv;
  int          e;

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  processor_step_ctrl_if #(.PC_W(7), .ST_W(4)) ctl ();

  processor_step_ctrl #(
    .RUN_DIV     (4),
    .DIV_W       (3),
    .PC_W        (7),
    .ST_W        (4),
    .FETCH_STATE (4'd0)
  ) dut (
    .Clock  (Clock),
    .ResetN (ResetN),
    .ctl    (ctl)
  );

  // Processor model: two states per instruction, PC advances after state 1.
  always_comb begin
    adv           = model_en - en_base;
    ctl.PC        = 7'(pc_base + adv / 2);
    ctl.ProcState = 4'(adv % 2);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) tick();
  endtask

  task automatic expect_en(input int at);
    exp_cnt = exp_cnt + 16'd1;
    sb.push_back('{at, exp_cnt});
  endtask

  task automatic step_pulse();
    ctl.StepReq = 1'b1;
    expect_en(cyc + 1);
    tick();
    ctl.StepReq = 1'b0;
  endtask

  task automatic toggle();
    ctl.RunToggle = 1'b1;
    tick();
    ctl.RunToggle = 1'b0;
  endtask

  always @(negedge Clock) begin
    if (ResetN === 1'b1 && ctl.ProcEn === 1'b1) begin
      check("en_expected", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        got = sb.pop_front();
        check("en_cycle", cyc, got.at);
        check("en_count", ctl.EnCount, got.cnt);
      end
      model_en = model_en + 1;
    end
  end

  initial begin
    ctl.StepReq   = 1'b0;
    ctl.RunToggle = 1'b0;
    ctl.BreakEn   = 1'b0;
    ctl.BreakPC   = '0;
    ResetN        = 1'b0;
    tick(2);
    check("rst_en", ctl.ProcEn, 0);
    check("rst_mode", ctl.Mode, 0);
    check("rst_halted", ctl.Halted, 1);
    check("rst_count", ctl.EnCount, 0);
    ResetN = 1'b1;
    tick(20);
    check("idle_mode", ctl.Mode, 0);
    check("idle_no_en", sb.size(), 0);

    // Single steps
    step_pulse();
    check("step_mode", ctl.Mode, 1);
    check("step_halted", ctl.Halted, 0);
    check("step_en", ctl.ProcEn, 1);
    tick();
    check("step_done_mode", ctl.Mode, 0);
    check("step_done_en", ctl.ProcEn, 0);
    tick(2);
    step_pulse();
    tick(2);
    step_pulse();
    tick(2);
    check("step_count3", ctl.EnCount, 3);

    // Free run, then stop
    toggle();
    e = cyc;
    for (int i = 1; i <= 3; i++) expect_en(e + 4 * i);
    tick(2);
    check("run_mode", ctl.Mode, 2);
    check("run_halted", ctl.Halted, 0);
    wait_until(e + 14);
    toggle();
    check("run_stop_mode", ctl.Mode, 0);
    tick(12);
    check("run_drained", sb.size(), 0);

    // Breakpoint at PC 05, then resume past it
    en_base     = model_en;
    pc_base     = 3;
    ctl.BreakPC = 7'h05;
    ctl.BreakEn = 1'b1;
    tick();
    toggle();
    e = cyc;
    for (int i = 1; i <= 4; i++) expect_en(e + 4 * i);
    wait_until(e + 22);
    check("brk_mode", ctl.Mode, 3);
    check("brk_halted", ctl.Halted, 1);
    check("brk_en", ctl.ProcEn, 0);
    tick(10);
    check("brk_hold", ctl.Mode, 3);
    check("brk_drained", sb.size(), 0);
    toggle();
    e = cyc;
    for (int i = 1; i <= 3; i++) expect_en(e + 4 * i);
    tick(2);
    check("resume_mode", ctl.Mode, 2);
    wait_until(e + 14);
    toggle();
    check("resume_stop_mode", ctl.Mode, 0);
    tick(4);
    check("resume_drained", sb.size(), 0);

    // Simultaneous requests, and StepReq ignored in RUN
    ctl.BreakEn   = 1'b0;
    ctl.StepReq   = 1'b1;
    ctl.RunToggle = 1'b1;
    tick();
    ctl.StepReq   = 1'b0;
    ctl.RunToggle = 1'b0;
    e = cyc;
    check("coll_mode", ctl.Mode, 2);
    check("coll_en", ctl.ProcEn, 0);
    expect_en(e + 4);
    expect_en(e + 8);
    wait_until(e + 5);
    ctl.StepReq = 1'b1;
    tick();
    ctl.StepReq = 1'b0;
    wait_until(e + 10);
    toggle();
    tick(6);
    check("coll_drained", sb.size(), 0);

    // EnCount wrap
    @(negedge Clock);
    force dut.en_count = 16'hFFFF;
    tick();
    release dut.en_count;
    exp_cnt = 16'hFFFF;
    check("wrap_preload", ctl.EnCount, 16'hFFFF);
    step_pulse();
    tick(2);
    check("wrap_count", ctl.EnCount, 0);

    // Asynchronous reset in the middle of RUN
    toggle();
    e = cyc;
    expect_en(e + 4);
    wait_until(e + 6);
    ResetN = 1'b0;
    #1;
    exp_cnt = '0;
    check("mid_rst_en", ctl.ProcEn, 0);
    check("mid_rst_mode", ctl.Mode, 0);
    check("mid_rst_halted", ctl.Halted, 1);
    check("mid_rst_count", ctl.EnCount, 0);
    tick(2);
    ResetN = 1'b1;
    tick(12);
    check("post_rst_mode", ctl.Mode, 0);
    check("final_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
